// File: rtl/data_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : data_mem_arbiter                                              |
// | Brief    : round-robin core/debug arbiter for the 32x8 data memory, with |
// |            optional debug lock (enabled by DATA_MEM_ARB_LOCK_EN)         |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module data_mem_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 8,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_stall,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

`ifdef DATA_MEM_ARB_LOCK_EN
  localparam logic c_lock_en = 1'b1;
`else
  localparam logic c_lock_en = 1'b0;
`endif
  localparam logic [7:0] c_lock_max = 8'(LOCK_MAX);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_LOCK = 1'b1
  } state_t;

  state_t            r_state, w_state_nxt;
  logic              r_last_dbg, w_last_dbg_nxt;
  logic [7:0]        r_lock_cnt, w_lock_cnt_nxt;
  logic              w_core_gnt, w_dbg_gnt;
  logic              r_core_rvalid, r_dbg_rvalid;
  logic [DATA_W-1:0] r_core_rdata, r_dbg_rdata;

  // Grants are held off entirely while reset is high.
  always_comb begin
    w_core_gnt = 1'b0;
    w_dbg_gnt  = 1'b0;
    if (!reset) begin
      if (r_state == S_LOCK) begin
        w_dbg_gnt = dbg_req;
      end else if (core_req && dbg_req) begin
        w_core_gnt = r_last_dbg;
        w_dbg_gnt  = !r_last_dbg;
      end else begin
        w_core_gnt = core_req;
        w_dbg_gnt  = dbg_req;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_lock_cnt_nxt = r_lock_cnt;
    w_last_dbg_nxt = r_last_dbg;
    if (w_core_gnt || w_dbg_gnt) begin
      w_last_dbg_nxt = w_dbg_gnt;
    end
    case (r_state)
      S_IDLE: begin
        // A one-grant limit is satisfied by the entering grant itself.
        if (c_lock_en && w_dbg_gnt && dbg_lock && (c_lock_max > 8'd1)) begin
          w_state_nxt    = S_LOCK;
          w_lock_cnt_nxt = 8'd1;
        end
      end
      S_LOCK: begin
        if (w_dbg_gnt) begin
          w_lock_cnt_nxt = r_lock_cnt + 8'd1;
        end
        if (!dbg_lock || (w_dbg_gnt && (w_lock_cnt_nxt >= c_lock_max))) begin
          w_state_nxt    = S_IDLE;
          w_lock_cnt_nxt = 8'd0;
          w_last_dbg_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_lock_cnt_nxt = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_last_dbg    <= 1'b1;
      r_lock_cnt    <= 8'd0;
      r_core_rvalid <= 1'b0;
      r_dbg_rvalid  <= 1'b0;
      r_core_rdata  <= '0;
      r_dbg_rdata   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_last_dbg    <= w_last_dbg_nxt;
      r_lock_cnt    <= w_lock_cnt_nxt;
      r_core_rvalid <= w_core_gnt && !core_we;
      r_dbg_rvalid  <= w_dbg_gnt && !dbg_we;
      if (w_core_gnt && !core_we) begin
        r_core_rdata <= mem_rdata;
      end
      if (w_dbg_gnt && !dbg_we) begin
        r_dbg_rdata <= mem_rdata;
      end
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_core_gnt) begin
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else if (w_dbg_gnt) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  assign core_gnt    = w_core_gnt;
  assign dbg_gnt     = w_dbg_gnt;
  assign core_stall  = core_req && !w_core_gnt;
  // A read pending across a reset assertion is dropped.
  assign core_rvalid = r_core_rvalid && !reset;
  assign dbg_rvalid  = r_dbg_rvalid && !reset;
  assign core_rdata  = r_core_rdata;
  assign dbg_rdata   = r_dbg_rdata;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_data_mem_arbiter                                           |
// | Brief    : scoreboard bench for data_mem_arbiter (either lock build)     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_data_mem_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       core_req, core_we, core_gnt, core_stall, core_rvalid;
  logic [4:0] core_addr;
  logic [7:0] core_wdata, core_rdata;
  logic       dbg_req, dbg_we, dbg_lock, dbg_gnt, dbg_rvalid;
  logic [4:0] dbg_addr;
  logic [7:0] dbg_wdata, dbg_rdata;
  logic       mem_we;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;

  logic       mem_init;
  logic [7:0] mem    [32];
  logic [7:0] shadow [32];

  typedef struct packed {
    logic [1:0] gnt;
    logic       we;
    logic [4:0] addr;
    logic [7:0] wdata;
  } gexp_t;

  typedef struct packed {
    logic [1:0] vld;
    logic [7:0] data;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  gexp_t mg;
  rexp_t mr;
  int    total = 0;
  int    bad   = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.ADDR_W(5), .DATA_W(8), .LOCK_MAX(16)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'hA0 + 8'(i);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT issues a grant or read data.
  always @(negedge clk) begin
    if (core_gnt || dbg_gnt) begin
      if (gq.size() == 0) begin
        chk("unexpected_gnt", {30'd0, core_gnt, dbg_gnt}, 32'd0);
      end else begin
        mg = gq.pop_front();
        chk("gnt_port", {30'd0, core_gnt, dbg_gnt}, {30'd0, mg.gnt});
        chk("mem_we", {31'd0, mem_we}, {31'd0, mg.we});
        chk("mem_addr", {27'd0, mem_addr}, {27'd0, mg.addr});
        chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, mg.wdata});
      end
    end
    if (core_rvalid || dbg_rvalid) begin
      if (rq.size() == 0) begin
        chk("unexpected_rvalid", {30'd0, core_rvalid, dbg_rvalid}, 32'd0);
      end else begin
        mr = rq.pop_front();
        chk("rvalid_port", {30'd0, core_rvalid, dbg_rvalid}, {30'd0, mr.vld});
        chk("rdata", {24'd0, (core_rvalid ? core_rdata : dbg_rdata)}, {24'd0, mr.data});
      end
    end
  end

  // win: 0 = no grant, 1 = core, 2 = debug. Called just after a rising edge.
  task automatic cyc(input logic cr, input logic cw, input logic [4:0] ca, input logic [7:0] cd,
                     input logic dr, input logic dw, input logic [4:0] da, input logic [7:0] dd,
                     input logic lk, input int win);
    gexp_t g;
    rexp_t r;
    core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
    dbg_req  = dr; dbg_we  = dw; dbg_addr  = da; dbg_wdata  = dd;
    dbg_lock = lk;
    if (win == 1) begin
      g = '{gnt: 2'b10, we: cw, addr: ca, wdata: cd};
      gq.push_back(g);
      if (cw) shadow[ca] = cd;
      else begin r = '{vld: 2'b10, data: shadow[ca]}; rq.push_back(r); end
    end else if (win == 2) begin
      g = '{gnt: 2'b01, we: dw, addr: da, wdata: dd};
      gq.push_back(g);
      if (dw) shadow[da] = dd;
      else begin r = '{vld: 2'b01, data: shadow[da]}; rq.push_back(r); end
    end
    @(negedge clk);
    chk("core_stall", {31'd0, core_stall}, {31'd0, (cr && (win != 1))});
    if (win == 0) begin
      chk("idle_mem_we", {31'd0, mem_we}, 32'd0);
      chk("idle_mem_addr", {27'd0, mem_addr}, 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state();
    chk("rst_core_gnt", {31'd0, core_gnt}, 32'd0);
    chk("rst_dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_core_rvalid", {31'd0, core_rvalid}, 32'd0);
    chk("rst_dbg_rvalid", {31'd0, dbg_rvalid}, 32'd0);
    chk("rst_core_rdata", {24'd0, core_rdata}, 32'd0);
    chk("rst_dbg_rdata", {24'd0, dbg_rdata}, 32'd0);
  endtask

  initial begin
    int w;
    mem_init = 1'b1;
    reset = 1'b1;
    core_req = 1'b1; core_we = 1'b0; core_addr = 5'd4; core_wdata = 8'd0;
    dbg_req  = 1'b1; dbg_we  = 1'b0; dbg_addr  = 5'd9; dbg_wdata  = 8'd0;
    dbg_lock = 1'b0;
    for (int i = 0; i < 32; i++) shadow[i] = 8'hA0 + 8'(i);

    // Reset held two cycles with both ports requesting.
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk_reset_state();
    end
    mem_init = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Continuous contention: core wins first, then strict alternation.
    cyc(1, 0, 5'd4, 8'd0, 1, 0, 5'd9, 8'd0, 0, 1);
    cyc(1, 0, 5'd4, 8'd0, 1, 0, 5'd9, 8'd0, 0, 2);
    cyc(1, 0, 5'd4, 8'd0, 1, 0, 5'd9, 8'd0, 0, 1);
    cyc(1, 0, 5'd4, 8'd0, 1, 0, 5'd9, 8'd0, 0, 2);

    // Core write then read-back of the same address.
    cyc(1, 1, 5'd3, 8'h5A, 0, 0, 5'd0, 8'd0, 0, 1);
    cyc(1, 0, 5'd3, 8'h00, 0, 0, 5'd0, 8'd0, 0, 1);
    chk("core_rvalid_5a", {31'd0, core_rvalid}, 32'd1);
    chk("core_rdata_5a", {24'd0, core_rdata}, 32'h5A);

    // Debug read-after-write, then a cross-port conflict on one address.
    cyc(0, 0, 5'd0, 8'd0, 1, 1, 5'd17, 8'h3C, 0, 2);
    cyc(0, 0, 5'd0, 8'd0, 1, 0, 5'd17, 8'h00, 0, 2);
    cyc(1, 1, 5'd20, 8'h77, 1, 0, 5'd20, 8'h00, 0, 1);
    cyc(0, 0, 5'd0, 8'd0, 1, 0, 5'd20, 8'h00, 0, 2);
    cyc(0, 0, 5'd0, 8'd0, 0, 0, 5'd0, 8'd0, 0, 0);

    // Sustained lock request against a competing core.
    for (int i = 0; i < 20; i++) begin
`ifdef DATA_MEM_ARB_LOCK_EN
      w = (i == 0 || i == 17) ? 1 : 2;
`else
      w = (i % 2 == 0) ? 1 : 2;
`endif
      cyc(1, 0, 5'd5, 8'd0, 1, 0, 5'd6, 8'd0, 1, w);
    end
    cyc(0, 0, 5'd0, 8'd0, 0, 0, 5'd0, 8'd0, 0, 0);

    // Lock dropped after three locked grants.
    cyc(0, 0, 5'd0, 8'd0, 1, 0, 5'd10, 8'd0, 1, 2);
`ifdef DATA_MEM_ARB_LOCK_EN
    cyc(1, 0, 5'd11, 8'd0, 1, 0, 5'd10, 8'd0, 1, 2);
`else
    cyc(1, 0, 5'd11, 8'd0, 1, 0, 5'd10, 8'd0, 1, 1);
`endif
    cyc(1, 0, 5'd11, 8'd0, 1, 0, 5'd10, 8'd0, 1, 2);
    cyc(0, 0, 5'd0, 8'd0, 1, 0, 5'd10, 8'd0, 0, 2);
    cyc(1, 0, 5'd11, 8'd0, 1, 0, 5'd10, 8'd0, 0, 1);

    // Reset in the middle of a lock drops the pending read.
    cyc(0, 0, 5'd0, 8'd0, 1, 1, 5'd8, 8'h11, 1, 2);
`ifdef DATA_MEM_ARB_LOCK_EN
    cyc(1, 0, 5'd2, 8'd0, 1, 0, 5'd8, 8'h00, 1, 2);
`else
    cyc(1, 0, 5'd2, 8'd0, 1, 0, 5'd8, 8'h00, 1, 1);
`endif
    void'(rq.pop_back());
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_core_gnt", {31'd0, core_gnt}, 32'd0);
    chk("midrst_dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
    chk("midrst_core_rvalid", {31'd0, core_rvalid}, 32'd0);
    chk("midrst_dbg_rvalid", {31'd0, dbg_rvalid}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(1, 0, 5'd2, 8'd0, 1, 0, 5'd8, 8'h00, 1, 1);
    cyc(0, 0, 5'd0, 8'd0, 1, 0, 5'd8, 8'h00, 0, 2);
    cyc(0, 0, 5'd0, 8'd0, 0, 0, 5'd0, 8'd0, 0, 0);
    cyc(0, 0, 5'd0, 8'd0, 0, 0, 5'd0, 8'd0, 0, 0);

    chk("gnt_queue_drained", gq.size(), 32'd0);
    chk("rd_queue_drained", rq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
